// File: rtl/trg_pls_pkg.sv
// Shared types and frame layout for the trigger pulse scheduler.
package trg_pls_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } trg_state_e;

  localparam int FRM_W      = 24;
  localparam int TGT_MSB    = 23;
  localparam int TGT_LSB    = 21;
  localparam int REGSEL_BIT = 20;
  localparam int RSVD_MSB   = 19;
  localparam int RSVD_LSB   = 16;
  localparam int VAL_MSB    = 15;
  localparam int VAL_LSB    = 0;

  localparam logic [2:0] TGT_GLOBAL = 3'd7;

  localparam int CMD_ARM   = 0;
  localparam int CMD_ABORT = 1;
  localparam int CMD_FIRE  = 2;

  localparam logic [4:0] BITCNT_FRAME = 5'd24;
  localparam logic [4:0] BITCNT_SAT   = 5'd25;

endpackage

// File: rtl/trg_pls_spi_rx.sv
// SPI mode-0 frame receiver: synchronizes the pins, shifts 24-bit frames,
// validates length and target, and flags malformed frames.
module trg_pls_spi_rx
  import trg_pls_pkg::*;
#(
  parameter int N_CH        = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             spi_clk_i,
  input  logic             spi_cs_i,
  input  logic             spi_mosi_i,
  output logic             frame_valid_o,
  output logic [FRM_W-1:0] frame_word_o,
  output logic             frame_err_o
);

  // frame_valid_o is a one-cycle strobe with no back-pressure: frame_word_o
  // is stable from that cycle until the next strobe and must be consumed then.

  localparam logic [3:0] N_CH_L = 4'(N_CH);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [FRM_W-1:0]       shift_q, shift_d, word_q, word_d;
  logic [4:0]             bitcnt_q, bitcnt_d;
  logic                   fv_q, fv_d, fe_q, fe_d;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise, cs_rise, tgt_ok;
  logic [2:0]             tgt;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign tgt       = shift_q[TGT_MSB:TGT_LSB];
  assign tgt_ok    = (tgt == TGT_GLOBAL) || ({1'b0, tgt} < N_CH_L);

  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    word_d   = word_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;
    if (cs_rise) begin
      bitcnt_d = '0;
      if (bitcnt_q == BITCNT_FRAME) begin
        if (tgt_ok) begin
          fv_d   = 1'b1;
          word_d = shift_q;
        end else begin
          fe_d = 1'b1;
        end
      end else if (bitcnt_q != '0) begin
        fe_d = 1'b1;
      end
    end else if (!cs_s && sclk_rise) begin
      shift_d = {shift_q[FRM_W-2:0], mosi_s};
      if (bitcnt_q != BITCNT_SAT) bitcnt_d = bitcnt_q + 5'd1;
    end
  end

  // Chip select resets to its idle (high) level so reset release never
  // looks like a frame end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      word_q      <= '0;
      fv_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      word_q      <= word_d;
      fv_q        <= fv_d;
      fe_q        <= fe_d;
    end
  end

  assign frame_valid_o = fv_q;
  assign frame_word_o  = word_q;
  assign frame_err_o   = fe_q;

endmodule

// File: rtl/trg_pls_scheduler.sv
// Multi-channel delayed trigger pulse scheduler programmed over SPI.
// Optional software fire command is compiled in with TRG_PLS_SW_TRIG_EN.
module trg_pls_scheduler
  import trg_pls_pkg::*;
#(
  parameter int N_CH        = 5,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_50,
  input  logic            reset,
  input  logic            spi_clk,
  input  logic            spi_cs,
  input  logic            spi_mosi,
  input  logic            trg_in,
  output logic [N_CH-1:0] trg_pls_triggersignal,
  output logic            busy,
  output logic            frame_err,
  output trg_state_e      dbg_state_o
);

  logic             rx_valid;
  logic [FRM_W-1:0] rx_word;

  trg_pls_spi_rx #(
    .N_CH       (N_CH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk_i        (clk_50),
    .rst_i        (reset),
    .spi_clk_i    (spi_clk),
    .spi_cs_i     (spi_cs),
    .spi_mosi_i   (spi_mosi),
    .frame_valid_o(rx_valid),
    .frame_word_o (rx_word),
    .frame_err_o  (frame_err)
  );

  trg_state_e             state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [N_CH-1:0]        out_q, out_d, hit;
  logic [CNT_W-1:0]       delay_q [N_CH];
  logic [CNT_W-1:0]       width_q [N_CH];
  logic [SYNC_STAGES-1:0] trg_sync_q;
  logic                   trg_prev_q, trg_rise_q, trg_s;
  logic                   is_global, cmd_arm, cmd_abort, start, wr_en, all_done;
  logic [2:0]             wr_tgt;
  logic                   wr_sel;
  logic [CNT_W-1:0]       wr_val;
  logic [CNT_W:0]         ch_end;
  logic [3:0]             unused_rsvd;

  assign trg_s       = trg_sync_q[SYNC_STAGES-1];
  assign wr_tgt      = rx_word[TGT_MSB:TGT_LSB];
  assign wr_sel      = rx_word[REGSEL_BIT];
  assign wr_val      = CNT_W'(rx_word[VAL_MSB:VAL_LSB]);
  assign unused_rsvd = rx_word[RSVD_MSB:RSVD_LSB];
  assign is_global   = rx_valid && (wr_tgt == TGT_GLOBAL);
  assign cmd_arm     = is_global && rx_word[CMD_ARM];
  assign cmd_abort   = is_global && rx_word[CMD_ABORT];
  assign wr_en       = rx_valid && (wr_tgt != TGT_GLOBAL) && (state_q == ST_IDLE);

`ifdef TRG_PLS_SW_TRIG_EN
  assign start = trg_rise_q || (is_global && rx_word[CMD_FIRE]);
`else
  assign start = trg_rise_q;
`endif

  // Window and completion use CNT_W+1 bits so delay+width never wraps.
  always_comb begin
    hit      = '0;
    all_done = 1'b1;
    ch_end   = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_end = (width_q[i] != '0) ? ({1'b0, delay_q[i]} + {1'b0, width_q[i]}) : '0;
      if (ch_end > {1'b0, count_q}) all_done = 1'b0;
      hit[i] = (width_q[i] != '0) && (delay_q[i] <= count_q) &&
               ({1'b0, count_q} < ch_end);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (start) begin
          state_d = ST_RUN;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (count_q != '1) count_d = count_q + CNT_W'(1);
        if (all_done || (count_q == '1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cmd_abort) state_d = ST_IDLE;
  end

  assign out_d = ((state_q == ST_RUN) && !cmd_abort) ? hit : '0;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      out_q      <= '0;
      trg_sync_q <= '0;
      trg_prev_q <= 1'b0;
      trg_rise_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        delay_q[i] <= '0;
        width_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      out_q      <= out_d;
      trg_sync_q <= {trg_sync_q[SYNC_STAGES-2:0], trg_in};
      trg_prev_q <= trg_s;
      trg_rise_q <= trg_s & ~trg_prev_q;
      if (wr_en) begin
        for (int i = 0; i < N_CH; i++) begin
          if (wr_tgt == 3'(i)) begin
            if (wr_sel) width_q[i] <= wr_val;
            else        delay_q[i] <= wr_val;
          end
        end
      end
    end
  end

  assign trg_pls_triggersignal = out_q;
  assign busy                  = (state_q != ST_IDLE);
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_trg_pls_scheduler.sv
// Directed bench for trg_pls_scheduler; build with TRG_PLS_SW_TRIG_EN to
// exercise the software fire command.
module tb_trg_pls_scheduler;
  import trg_pls_pkg::*;

  localparam int N_CH = 5;
  localparam logic [23:0] F_ARM   = 24'hE00001;
  localparam logic [23:0] F_ABORT = 24'hE00002;
  localparam logic [23:0] F_BOTH  = 24'hE00003;
  localparam logic [23:0] F_FIRE  = 24'hE00004;

  logic            clk_50 = 1'b0;
  logic            reset;
  logic            spi_clk, spi_cs, spi_mosi, trg_in;
  logic [N_CH-1:0] out;
  logic            busy, frame_err;
  trg_state_e      st;

  trg_pls_scheduler #(.N_CH(N_CH), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk_50               (clk_50),
    .reset                (reset),
    .spi_clk              (spi_clk),
    .spi_cs               (spi_cs),
    .spi_mosi             (spi_mosi),
    .trg_in               (trg_in),
    .trg_pls_triggersignal(out),
    .busy                 (busy),
    .frame_err            (frame_err),
    .dbg_state_o          (st)
  );

  always #5 clk_50 = ~clk_50;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  int first_hi [N_CH];
  int hi_cnt [N_CH];
  int both_cnt, both_first, fe_cnt, fv_cyc, last_busy;
  logic [N_CH-1:0] post_fv_out;
  logic            post_fv_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N_CH; i++) begin
      first_hi[i] = -1;
      hi_cnt[i]   = 0;
    end
    both_cnt     = 0;
    both_first   = -1;
    fe_cnt       = 0;
    fv_cyc       = -100;
    last_busy    = -1;
    post_fv_out  = 'x;
    post_fv_busy = 1'bx;
  endtask

  // One clock: advance past the rising edge, then sample on the falling edge.
  task automatic step();
    @(posedge clk_50);
    cyc++;
    @(negedge clk_50);
    for (int i = 0; i < N_CH; i++) begin
      if (out[i]) begin
        if (first_hi[i] < 0) first_hi[i] = cyc;
        hi_cnt[i]++;
      end
    end
    if (out[0] && out[4]) begin
      both_cnt++;
      if (both_first < 0) both_first = cyc;
    end
    if (frame_err) fe_cnt++;
    if (busy) last_busy = cyc;
    if (cyc == fv_cyc + 1) begin
      post_fv_out  = out;
      post_fv_busy = busy;
    end
    if (dut.u_rx.frame_valid_o) fv_cyc = cyc;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic spi_send(input logic [23:0] w, input int nbits);
    spi_cs = 1'b0;
    steps(4);
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = (b < 24) ? w[23-b] : 1'b0;
      steps(4);
      spi_clk = 1'b1;
      steps(4);
      spi_clk = 1'b0;
    end
    steps(4);
    spi_cs = 1'b1;
    steps(8);
  endtask

  function automatic logic [23:0] mk(input logic [2:0] t, input logic sel, input logic [15:0] v);
    return {t, sel, 4'h0, v};
  endfunction

  initial begin
    reset = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; trg_in = 1'b0;
    clr();
    steps(3);
    reset = 1'b0;
    step();
    chk("reset_out", 32'(out), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ferr", 32'(frame_err), 0);
    chk("reset_state", 32'(st), 32'(ST_IDLE));

    // Single channel, delay 10 width 5, with a re-trigger attempt during RUN.
    spi_send(mk(3'd0, 1'b0, 16'd10), 24);
    spi_send(mk(3'd0, 1'b1, 16'd5), 24);
    spi_send(F_ARM, 24);
    chk("armed_state", 32'(st), 32'(ST_ARMED));
    chk("armed_busy", 32'(busy), 1);
    clr();
    trg_in = 1'b1; t0 = cyc + 1;
    steps(4);
    trg_in = 1'b0;
    steps(4);
    trg_in = 1'b1;
    steps(30);
    chk("c0_first", first_hi[0], t0 + 14);
    chk("c0_len", hi_cnt[0], 5);
    chk("c0_busy_end", last_busy, t0 + 18);
    chk("c0_idle", 32'(st), 32'(ST_IDLE));

    // Two overlapping channels.
    trg_in = 1'b0;
    spi_send(mk(3'd0, 1'b1, 16'd3), 24);
    spi_send(mk(3'd0, 1'b0, 16'd0), 24);
    spi_send(mk(3'd4, 1'b0, 16'd2), 24);
    spi_send(mk(3'd4, 1'b1, 16'd4), 24);
    spi_send(F_ARM, 24);
    clr();
    trg_in = 1'b1; t0 = cyc + 1;
    steps(20);
    chk("ov_first0", first_hi[0], t0 + 4);
    chk("ov_len0", hi_cnt[0], 3);
    chk("ov_first4", first_hi[4], t0 + 6);
    chk("ov_len4", hi_cnt[4], 4);
    chk("ov_both_cnt", both_cnt, 1);
    chk("ov_both_at", both_first, t0 + 6);
    chk("ov_busy_end", last_busy, t0 + 9);

    // Malformed frames: short, bad target, long.
    trg_in = 1'b0;
    clr();
    spi_send(mk(3'd1, 1'b1, 16'h0077), 23);
    spi_send(mk(3'd5, 1'b0, 16'h0033), 24);
    spi_send(mk(3'd1, 1'b0, 16'h0055), 26);
    chk("ferr_count", fe_cnt, 3);
    chk("ferr_w1", 32'(dut.width_q[1]), 0);
    chk("ferr_d1", 32'(dut.delay_q[1]), 0);
    chk("ferr_w0", 32'(dut.width_q[0]), 3);

    // Abort and arm together in IDLE: abort wins.
    clr();
    spi_send(F_BOTH, 24);
    chk("both_cmd_busy", last_busy, -1);

    // Write during RUN is dropped; abort ends RUN at once.
    spi_send(mk(3'd0, 1'b1, 16'd1000), 24);
    spi_send(F_ARM, 24);
    clr();
    trg_in = 1'b1;
    steps(10);
    chk("run_busy", 32'(busy), 1);
    spi_send(mk(3'd0, 1'b1, 16'd100), 24);
    chk("run_wr_drop", 32'(dut.width_q[0]), 1000);
    chk("run_out0", 32'(out[0]), 1);
    spi_send(F_ABORT, 24);
    chk("abort_out", 32'(post_fv_out), 0);
    chk("abort_busy", 32'(post_fv_busy), 0);
    chk("abort_state", 32'(st), 32'(ST_IDLE));
    chk("abort_w0", 32'(dut.width_q[0]), 1000);

    // Reset in the middle of RUN.
    trg_in = 1'b0;
    step();
    spi_send(F_ARM, 24);
    clr();
    trg_in = 1'b1;
    steps(20);
    chk("pre_rst_out0", 32'(out[0]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_out", 32'(out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(st), 32'(ST_IDLE));
    chk("rst_w0", 32'(dut.width_q[0]), 0);
    chk("rst_d4", 32'(dut.delay_q[4]), 0);
    chk("rst_w4", 32'(dut.width_q[4]), 0);
    step();
    trg_in = 1'b0;
    steps(4);
    clr();
    trg_in = 1'b1;
    steps(20);
    chk("post_rst_trg_busy", last_busy, -1);
    chk("post_rst_trg_out", hi_cnt[0], 0);
    chk("post_rst_ferr", fe_cnt, 0);

    // Software fire on channel 2 (delay 0, width 2).
    trg_in = 1'b0;
    spi_send(mk(3'd2, 1'b0, 16'd0), 24);
    spi_send(mk(3'd2, 1'b1, 16'd2), 24);
    spi_send(F_ARM, 24);
    clr();
    spi_send(F_FIRE, 24);
    steps(10);
`ifdef TRG_PLS_SW_TRIG_EN
    chk("fire_first", first_hi[2], fv_cyc + 2);
    chk("fire_len", hi_cnt[2], 2);
    chk("fire_idle", 32'(busy), 0);
`else
    chk("nofire_len", hi_cnt[2], 0);
    chk("nofire_state", 32'(st), 32'(ST_ARMED));
    spi_send(F_ABORT, 24);
    chk("nofire_abort", 32'(busy), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
